// File: rtl/iterative_divider_if.sv
// iterative_divider_if: valid/ready operand and result channels of the divider
interface iterative_divider_if #(parameter int DATA_WIDTH = 8);
  logic in_valid, in_ready, mode, out_valid, out_ready, div_by_zero, overflow;
  logic [DATA_WIDTH-1:0] data_in_a, data_in_b, quotient, remainder;
  modport master(
    output in_valid, mode, data_in_a, data_in_b, out_ready,
    input in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );
  modport slave(
    input in_valid, mode, data_in_a, data_in_b, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/iterative_divider.sv
// iterative_divider: restoring signed/unsigned divider, one quotient bit per clock
module iterative_divider #(
  parameter int DATA_WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  iterative_divider_if.slave bus
);
  localparam int W = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [W-1:0] pr, dq, dvs, a_mag, b_mag, nxt_pr, nxt_dq, q_fix, r_fix;
  logic [W:0] sh;
  logic a_neg, b_neg, sa, sb, ge, min_ovf, b_zero;
  // dq starts as the dividend magnitude and fills with quotient bits from the LSB
  always_comb begin
    a_neg = bus.mode & bus.data_in_a[W-1];
    b_neg = bus.mode & bus.data_in_b[W-1];
    a_mag = a_neg ? -bus.data_in_a : bus.data_in_a;
    b_mag = b_neg ? -bus.data_in_b : bus.data_in_b;
    b_zero = bus.data_in_b == '0;
    min_ovf = bus.mode && bus.data_in_a == MIN && bus.data_in_b == '1;
    sh = {pr, dq[W-1]};
    ge = sh >= {1'b0, dvs};
    nxt_pr = ge ? W'(sh - {1'b0, dvs}) : sh[W-1:0];
    nxt_dq = {dq[W-2:0], ge};
    q_fix = (sa ^ sb) ? -nxt_dq : nxt_dq;
    r_fix = sa ? -nxt_pr : nxt_pr;
  end
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      pr <= '0;
      dq <= '0;
      dvs <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      bus.quotient <= '0;
      bus.remainder <= '0;
      bus.div_by_zero <= 1'b0;
      bus.overflow <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.in_valid) begin
        cnt <= CW'(W);
        pr <= '0;
        dq <= a_mag;
        dvs <= b_mag;
        sa <= a_neg;
        sb <= b_neg;
        bus.div_by_zero <= b_zero;
        bus.overflow <= min_ovf;
        state <= (b_zero || min_ovf) ? DONE : CALC;
        if (b_zero) begin
          bus.quotient <= '1;
          bus.remainder <= bus.data_in_a;
        end else if (min_ovf) begin
          bus.quotient <= MIN;
          bus.remainder <= '0;
        end
      end
    end else if (state == CALC) begin
      pr <= nxt_pr;
      dq <= nxt_dq;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        state <= DONE;
        bus.quotient <= q_fix;
        bus.remainder <= r_fix;
      end
    end else if (bus.out_ready) begin
      state <= IDLE;
    end
endmodule
